// File: rtl/alu_issue_if.sv
// Issue-stage bus: fetch handshake, ALU operand/result link, write-back and debug taps.
`ifndef ALU_OP_AMT
`define ALU_OP_AMT 8
`endif

interface alu_issue_if #(
    parameter int unsigned data_bus_size = 8,
    parameter int unsigned reg_amt       = 8
);
    localparam int unsigned ra = $clog2(reg_amt);
    localparam int unsigned ow = $clog2(`ALU_OP_AMT);

    logic                     instr_valid;
    logic [ow+3*ra-1:0]       instr;
    logic                     instr_ready;
    logic [data_bus_size-1:0] alu_A;
    logic [data_bus_size-1:0] alu_B;
    logic [ow-1:0]            alu_op;
    logic [data_bus_size-1:0] alu_result;
    logic                     wb_valid;
    logic [ra-1:0]            wb_addr;
    logic [data_bus_size-1:0] wb_data;
    logic [ra-1:0]            dbg_addr;
    logic [data_bus_size-1:0] dbg_data;
    logic [15:0]              retired;

    modport master (
        output instr_valid, instr, alu_result, dbg_addr,
        input  instr_ready, alu_A, alu_B, alu_op, wb_valid, wb_addr, wb_data, dbg_data, retired
    );

    modport slave (
        input  instr_valid, instr, alu_result, dbg_addr,
        output instr_ready, alu_A, alu_B, alu_op, wb_valid, wb_addr, wb_data, dbg_data, retired
    );
endinterface

// File: rtl/alu_issue.sv
// Issue/write-back stage: reads the regfile with forwarding, holds ALU operands for one
// execute cycle and writes the ALU result back.
`ifndef ALU_OP_AMT
`define ALU_OP_AMT 8
`endif

module alu_issue #(
    parameter int unsigned data_bus_size = 8,
    parameter int unsigned reg_amt       = 8
) (
    input logic         clk,
    input logic         rst_n,
    alu_issue_if.slave  bus
);
    localparam int unsigned ra = $clog2(reg_amt);
    localparam int unsigned ow = $clog2(`ALU_OP_AMT);
    localparam logic [ow-1:0] OpNop = '0;
    localparam logic [ow-1:0] OpLdi = ow'(1);

    logic [data_bus_size-1:0] regs_q [reg_amt];
    logic                     ready_q;
    logic                     ex_valid_q, ex_valid_d;
    logic [ra-1:0]            ex_rd_q, ex_rd_d;
    logic [ow-1:0]            op_q, op_d;
    logic [data_bus_size-1:0] a_q, a_d;
    logic [data_bus_size-1:0] b_q, b_d;
    logic [15:0]              retired_q;

    logic [ow-1:0]            dec_op;
    logic [ra-1:0]            dec_rd, dec_rs1, dec_rs2;
    logic [2*ra-1:0]          imm_raw;
    logic [data_bus_size-1:0] imm;
    logic                     accept, fwd_en, wb_en;
    logic [data_bus_size-1:0] opnd_a, opnd_b;

    assign dec_op  = bus.instr[ow+3*ra-1 -: ow];
    assign dec_rd  = bus.instr[3*ra-1 -: ra];
    assign dec_rs1 = bus.instr[2*ra-1 -: ra];
    assign dec_rs2 = bus.instr[ra-1:0];
    assign imm_raw = {dec_rs1, dec_rs2};
    assign imm     = data_bus_size'(imm_raw);

    assign accept = bus.instr_valid && ready_q;
    assign wb_en  = ex_valid_q && (op_q != OpNop) && (ex_rd_q != '0);
    // Forwarding mirrors write-back, so r0 and bubbles are never forwarded.
    assign fwd_en = wb_en;
    assign opnd_a = (fwd_en && ex_rd_q == dec_rs1) ? bus.alu_result : regs_q[dec_rs1];
    assign opnd_b = (fwd_en && ex_rd_q == dec_rs2) ? bus.alu_result : regs_q[dec_rs2];

    always_comb begin
        ex_valid_d = accept;
        ex_rd_d    = '0;
        op_d       = OpNop;
        a_d        = '0;
        b_d        = '0;
        if (accept) begin
            ex_rd_d = dec_rd;
            op_d    = dec_op;
            if (dec_op == OpLdi) begin
                a_d = imm;
            end else if (dec_op != OpNop) begin
                a_d = opnd_a;
                b_d = opnd_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q    <= 1'b0;
            ex_valid_q <= 1'b0;
            ex_rd_q    <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            retired_q  <= '0;
        end else begin
            ready_q    <= 1'b1;
            ex_valid_q <= ex_valid_d;
            ex_rd_q    <= ex_rd_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            if (ex_valid_q) retired_q <= retired_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < reg_amt; i++) regs_q[i] <= '0;
        end else if (wb_en) begin
            regs_q[ex_rd_q] <= bus.alu_result;
        end
    end

    assign bus.instr_ready = ready_q;
    assign bus.alu_A       = a_q;
    assign bus.alu_B       = b_q;
    assign bus.alu_op      = op_q;
    assign bus.wb_valid    = wb_en;
    assign bus.wb_addr     = ex_rd_q;
    assign bus.wb_data     = bus.alu_result;
    assign bus.dbg_data    = regs_q[bus.dbg_addr];
    assign bus.retired     = retired_q;
endmodule
